// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the serial magnitude comparator.
package serial_cmp_pkg;

    // Operand length used when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting for start, consuming bits, presenting a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_cmp_pkg

// File: rtl/bit_cmp_step.sv
// One MSB-first comparison step: folds the current bit pair into the
// running (decided, gt_f) flags. Once a difference has been seen, the
// later, less significant bits can no longer change the outcome.
module bit_cmp_step (
    input  logic a_bit_i,
    input  logic b_bit_i,
    input  logic decided_i,
    input  logic gt_f_i,
    output logic decided_o,
    output logic gt_f_o
);

    logic differ;

    assign differ = a_bit_i ^ b_bit_i;

    // The first differing bit decides; A wins exactly when its bit is the 1.
    always_comb begin
        decided_o = decided_i;
        gt_f_o    = gt_f_i;
        if (!decided_i && differ) begin
            decided_o = 1'b1;
            gt_f_o    = a_bit_i;
        end
    end

endmodule : bit_cmp_step

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator. Operands arrive MSB first, one
// bit pair per cycle with bit_valid high; after WIDTH valid bits the result
// is registered on eq/gt/lt and flagged by a one-cycle done pulse. The
// result stays on the outputs until the next comparison completes.
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    // Counter holds 0..WIDTH-1 only; it is never advanced past the last index.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             decided_q;
    logic             gt_f_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic             decided_d;
    logic             gt_f_d;

    bit_cmp_step u_step (
        .a_bit_i   (a_bit),
        .b_bit_i   (b_bit),
        .decided_i (decided_q),
        .gt_f_i    (gt_f_q),
        .decided_o (decided_d),
        .gt_f_o    (gt_f_d)
    );

    // Controller: sequences IDLE/RUN/DONE and registers every output so the
    // result flags and the done pulse change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_f_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        gt_f_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bit_valid) begin
                        decided_q <= decided_d;
                        gt_f_q    <= gt_f_d;
                        if (cnt_q == LAST_IDX) begin
                            // Last bit: the result uses the flags including this bit.
                            state_q <= ST_DONE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            eq_q    <= ~decided_d;
                            gt_q    <= decided_d & gt_f_d;
                            lt_q    <= decided_d & ~gt_f_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule : serial_mag_comparator

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator at WIDTH=4: directed table,
// hand-written reset/back-to-back sequences, and randomized operands
// checked against plain integer comparison.
module tb_serial_mag_comparator;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    int n_tests = 0;
    int n_fail  = 0;

    // Result the outputs must currently be holding, encoded {eq,gt,lt}.
    logic [2:0] held;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           gaps;
        logic [2:0]   exp;
    } vec_t;

    vec_t vecs[4];

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned comparison of the whole operands.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == b)     return 3'b100;
        else if (a > b) return 3'b010;
        else            return 3'b001;
    endfunction

    // Runs one comparison from IDLE: start, then W valid bits with `gaps`
    // idle cycles (random junk on the bit lines) before each. Returns in the
    // DONE cycle. Optionally pulses start during RUN, which must be ignored.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gaps, input bit mid_start, input logic [2:0] exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < gaps; g++) begin
                bit_valid = 1'b0;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                start     = mid_start;
                tick();
                start = 1'b0;
                check("busy_gap", busy, 1);
                check("done_gap", done, 0);
                check("held_gap", {eq, gt, lt}, held);
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            start     = mid_start && (i == W - 2);
            tick();
            bit_valid = 1'b0;
            start     = 1'b0;
            if (i > 0) begin
                check("busy_run", busy, 1);
                check("done_early", done, 0);
                check("held_run", {eq, gt, lt}, held);
            end else begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 0);
                check("result", {eq, gt, lt}, exp);
            end
        end
        held = exp;
        $display("[TB] cmp A=%b B=%b gaps=%0d -> eq=%b gt=%b lt=%b (exp %b)",
                 a, b, gaps, eq, gt, lt, exp);
    endtask

    // From the DONE cycle, step into IDLE and confirm the pulse ended.
    task automatic to_idle();
        tick();
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("held_idle", {eq, gt, lt}, held);
    endtask

    initial begin
        vecs[0] = '{a: 4'b1010, b: 4'b1010, gaps: 0, exp: 3'b100};
        vecs[1] = '{a: 4'b1100, b: 4'b1011, gaps: 0, exp: 3'b010};
        vecs[2] = '{a: 4'b0111, b: 4'b1000, gaps: 0, exp: 3'b001};
        vecs[3] = '{a: 4'b0110, b: 4'b0101, gaps: 2, exp: 3'b010};

        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        held = 3'b000;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", {eq, gt, lt}, 0);
        rst = 1'b0;

        // Bits offered in IDLE must not be counted or compared.
        for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            tick();
            check("idle_bits_ignored", {busy, done}, 0);
        end
        bit_valid = 1'b0;

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            run_cmp(vecs[v].a, vecs[v].b, vecs[v].gaps, 1'b0, vecs[v].exp);
            to_idle();
        end

        // Reset during RUN after two bits: aborts with no done, clears outputs.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            tick();
        end
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", {eq, gt, lt}, 0);
        held = 3'b000;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_done_after_rst", {busy, done}, 0);
        end
        run_cmp(4'b0001, 4'b0010, 0, 1'b0, 3'b001);
        to_idle();

        // Start ignored during RUN; start held through DONE (ignored there)
        // is taken in the following IDLE cycle for back-to-back operation.
        run_cmp(4'b1111, 4'b0000, 0, 1'b1, 3'b010);
        start = 1'b1;
        tick();
        check("start_ignored_in_done", busy, 0);
        check("done_one_cycle", done, 0);
        run_cmp(4'b0011, 4'b0101, 1, 1'b1, 3'b001);
        to_idle();

        // Randomized operands against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 15));
            rb = (r % 5 == 0) ? ra : W'($urandom_range(0, 15));
            run_cmp(ra, rb, int'($urandom_range(0, 2)), 1'($urandom), model(ra, rb));
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
                tick();
                check("b2b_idle", {busy, done}, 0);
            end else begin
                to_idle();
            end
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_mag_comparator
